// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction-memory read port, redirect input and decode handshake.
// The fetch unit is the master; the memory/execute/decode environment is the slave.
interface instr_fetch_unit_if;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign_err;
    logic        fetch_halted;

    modport master (
        input  fetch_en, imem_data, redirect_valid, redirect_pc, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc, misalign_err, fetch_halted
    );

    modport slave (
        output fetch_en, imem_data, redirect_valid, redirect_pc, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc, misalign_err, fetch_halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, prefetch FIFO and redirect/flush handling.
// Optional upper-bound fetch check is enabled by defining FETCH_BOUND_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter logic [31:0] MEM_LAST_ADDR = 32'd100
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;

    logic [31:0]      r_fifo_instr [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      r_last_instr;
    logic [31:0]      r_last_pc;
    logic             r_misalign;

    logic             w_nonempty;
    logic             w_pop;
    logic             w_space;
    logic             w_want_capture;
    logic             w_capture;
    logic             w_pc_inbound;
    logic             w_redirect_inbound;
    logic [31:0]      w_redirect_pc;

    assign w_nonempty     = (r_count != '0);
    assign w_pop          = w_nonempty && bus.instr_ready;
    assign w_space        = (r_count < CNT_W'(FIFO_DEPTH)) || w_pop;
    assign w_want_capture = (r_state == ST_RUN) && bus.fetch_en
                            && !bus.redirect_valid && w_space;
    assign w_redirect_pc  = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_BOUND_CHECK_EN
    assign w_pc_inbound       = (r_fetch_pc + 32'd3) <= MEM_LAST_ADDR;
    assign w_redirect_inbound = (w_redirect_pc + 32'd3) <= MEM_LAST_ADDR;
    assign bus.fetch_halted   = (r_state == ST_HALT);
`else
    logic w_unused_bound;
    assign w_unused_bound     = ^MEM_LAST_ADDR;
    assign w_pc_inbound       = 1'b1;
    assign w_redirect_inbound = 1'b1;
    assign bus.fetch_halted   = 1'b0;
`endif

    assign w_capture = w_want_capture && w_pc_inbound;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;

        // A redirect that coincides with fetch_en in IDLE keeps IDLE for one more cycle.
        unique case (r_state)
            ST_IDLE: begin
                if (!bus.redirect_valid && bus.fetch_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_want_capture && !w_pc_inbound) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.redirect_valid && w_redirect_inbound) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (bus.redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_pc;
        end else if (w_capture) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_misalign   <= 1'b0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else begin
            if (w_nonempty) begin
                r_last_instr <= r_fifo_instr[r_rd_ptr];
                r_last_pc    <= r_fifo_pc[r_rd_ptr];
            end
            if (bus.redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else begin
                if (w_capture) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_capture && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_capture && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_data;
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    // When empty, the head outputs replay the last head that was presented.
    assign bus.imem_addr    = r_fetch_pc;
    assign bus.instr_valid  = w_nonempty;
    assign bus.instr        = w_nonempty ? r_fifo_instr[r_rd_ptr] : r_last_instr;
    assign bus.instr_pc     = w_nonempty ? r_fifo_pc[r_rd_ptr]    : r_last_pc;
    assign bus.misalign_err = r_misalign;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        r_count <= CNT_W'(FIFO_DEPTH));

    a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
        r_fetch_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table plus hand sequences
// for misalign persistence, reset override, IDLE redirect, bound check and PC wrap.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .FIFO_DEPTH    (2),
        .MEM_LAST_ADDR (32'd100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0149_8333;
        if (a == 32'h0000_0004) return 32'h006E_8393;
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    typedef struct {
        logic        r;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic r, fe, rdy, rv, input logic [31:0] rpc,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ipc, input logic e_mis);
        vec_t v;
        v.r = r; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, fe, rdy, rv, input logic [31:0] rpc);
        rst                = r;
        bus.fetch_en       = fe;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_ipc, input logic e_mis, input logic e_halt,
                              input logic after_rst);
        check({tag, " imem_addr"}, bus.imem_addr, e_addr);
        check({tag, " instr_valid"}, {31'b0, bus.instr_valid}, {31'b0, e_valid});
        check({tag, " misalign_err"}, {31'b0, bus.misalign_err}, {31'b0, e_mis});
        check({tag, " fetch_halted"}, {31'b0, bus.fetch_halted}, {31'b0, e_halt});
        if (after_rst) begin
            check({tag, " instr"}, bus.instr, 32'h0);
            check({tag, " instr_pc"}, bus.instr_pc, 32'h0);
        end else if (e_valid) begin
            check({tag, " instr"}, bus.instr, mem_word(e_ipc));
            check({tag, " instr_pc"}, bus.instr_pc, e_ipc);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Basic fetch: valid two edges after reset release
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h04, 1, 32'h00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h08, 1, 32'h04, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0C, 1, 32'h08, 0));
        // Backpressure: 5 cycles not ready, FIFO fills at 2, address stalls at 8
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h04, 1, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h08, 1, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h08, 1, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h08, 1, 32'h00, 0));
        // Full FIFO with pop and capture together
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0C, 1, 32'h04, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h10, 1, 32'h08, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h14, 1, 32'h0C, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h14, 1, 32'h0C, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h14, 1, 32'h0C, 0));
        // Redirect while full, then redirect squashing a simultaneous pop
        tbl.push_back(mk(0, 1, 0, 1, 32'h20, 32'h20, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h24, 1, 32'h20, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h40, 32'h40, 0, 32'h00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h44, 1, 32'h40, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h48, 1, 32'h44, 0));
        // Misaligned redirect target
        tbl.push_back(mk(0, 1, 1, 1, 32'h16, 32'h14, 0, 32'h00, 1));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h18, 1, 32'h14, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            expect_out($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_valid,
                       tbl[i].e_ipc, tbl[i].e_mis, 1'b0, tbl[i].r);
        end

        // fetch_en=0: FIFO drains, PC holds, misalign_err stays set
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 32'h0);
            check($sformatf("sticky%0d misalign_err", i), {31'b0, bus.misalign_err}, 32'h1);
        end
        expect_out("fe0_drain", 32'h18, 0, 32'h0, 1, 0, 0);

        cyc(0, 0, 1, 1, 32'h100);
        expect_out("fe0_redirect", 32'h100, 0, 32'h0, 1, 0, 0);

        // Reset wins over a concurrent misaligned redirect
        cyc(1, 1, 1, 1, 32'h52);
        expect_out("rst_override", 32'h00, 0, 32'h0, 0, 0, 1);

        // Redirect in IDLE updates the PC but stays in IDLE
        cyc(0, 1, 1, 1, 32'h30);
        expect_out("idle_redir", 32'h30, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("idle_to_run", 32'h30, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("first_cap", 32'h34, 1, 32'h30, 0, 0, 0);

        // Approach MEM_LAST_ADDR=100: last in-bound capture is pc 96
        cyc(0, 1, 1, 1, 32'h58);
        expect_out("bnd_redir", 32'h58, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_88", 32'h5C, 1, 32'h58, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_92", 32'h60, 1, 32'h5C, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_96", 32'h64, 1, 32'h60, 0, 0, 0);
`ifdef FETCH_BOUND_CHECK_EN
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_halt", 32'h64, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_hold", 32'h64, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 1, 1, 32'h68);
        expect_out("bnd_oob_redir", 32'h68, 0, 32'h0, 0, 1, 0);
        cyc(0, 1, 1, 1, 32'h0);
        expect_out("bnd_resume", 32'h00, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("bnd_refetch", 32'h04, 1, 32'h00, 0, 0, 0);
`else
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("free_100", 32'h68, 1, 32'h64, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("free_104", 32'h6C, 1, 32'h68, 0, 0, 0);

        // 32-bit PC wrap
        cyc(0, 1, 1, 1, 32'hFFFF_FFF8);
        expect_out("wrap_redir", 32'hFFFF_FFF8, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("wrap_f8", 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("wrap_fc", 32'h0000_0000, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 1, 1, 0, 32'h0);
        expect_out("wrap_0", 32'h0000_0004, 1, 32'h0000_0000, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the fetch PC, drives the byte address to the instruction memory and captures the returned 32-bit instruction word.
- Buffers captured words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush.
- Sits between the instruction memory and the decode stage of the processor.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, 2..8).
- MEM_LAST_ADDR, 100, highest valid byte address of instruction memory; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = fetching permitted; 0 = hold the PC and issue no captures.
- imem_addr  out  32  byte address to instruction memory (the current fetch PC).
- imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle (byte at addr in [31:24]).
- redirect_valid  in  1  1-cycle redirect request from execute.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr  out  32  FIFO head instruction.
- instr_pc  out  32  PC of the FIFO head instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- misalign_err  out  1  sticky flag: a redirect target had pc[1:0] != 0.
- fetch_halted  out  1  fetch stopped by the bound check (optional feature only; tied 0 otherwise).

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - fetch_pc = RESET_PC; FIFO emptied; FSM = IDLE.
  - instr_valid = 0, instr = 0, instr_pc = 0, misalign_err = 0, fetch_halted = 0.
  - Reset overrides every other input, including mid-redirect or mid-handshake.
- imem_addr = fetch_pc, combinational from the register at all times.
- FSM:
  - IDLE: entered only from reset; no capture. Goes to RUN on the next edge when fetch_en=1.
  - RUN: normal fetch.
  - HALT: entered only with the optional feature.
- Pop: occurs when instr_valid && instr_ready.
- Capture condition, in RUN: fetch_en=1, redirect_valid=0, and (count < FIFO_DEPTH or a pop occurs this cycle).
  - On capture: push {imem_data, fetch_pc} and set fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - Capture and pop in the same cycle are legal when full; count is unchanged.
- Latency: the word for address A is visible on instr/instr_pc the cycle after the capture edge (one cycle from imem_addr=A to instr_valid).
- Full FIFO with no pop: fetch_pc holds, no push, imem_addr stable.
- Empty FIFO: instr_valid = 0; instr and instr_pc hold their last values (don't-care to consumers).
- Redirect (redirect_valid=1, any state except reset):
  - Flush all FIFO entries, including any pop in that cycle; decode must treat a simultaneous pop as squashed.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; no capture that cycle.
  - If redirect_pc[1:0] != 0, set misalign_err = 1. It clears only on rst.
  - A redirect in IDLE updates fetch_pc and stays in IDLE.
- fetch_en=0: no captures and no pc increment. Pops still drain the FIFO. Redirects still apply.
- FIFO: circular read/write pointers with wrap at FIFO_DEPTH, plus a count register of width clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - Before a capture, if fetch_pc + 3 > MEM_LAST_ADDR (32-bit compare), suppress the capture and move RUN -> HALT; fetch_halted = 1.
  - HALT performs no captures; the FIFO still drains.
  - A redirect to an in-bound target returns HALT -> RUN and clears fetch_halted.
  - A redirect to an out-of-bound target stays in HALT.
- Undefined: no bound logic; HALT is unreachable; fetch_halted is tied 0; the address runs freely.

Test Plan:
- Reset then fetch_en=1, instr_ready=1, memory holds 0x01498333 at 0 and 0x006E8393 at 4 -> imem_addr 0,4,8...; instr_valid rises 2 cycles after reset release with instr=0x01498333, instr_pc=0, then 0x006E8393 with instr_pc=4.
- instr_ready=0 for 5 cycles, FIFO_DEPTH=2 -> exactly 2 entries captured, imem_addr stalls at 8; on release, pcs 0,4,8 are delivered in order with no loss or duplication.
- Full FIFO with instr_ready=1 and a simultaneous capture -> count stays 2, one instruction delivered per cycle.
- redirect_valid with redirect_pc=0x20 while FIFO is full -> next cycle instr_valid=0, imem_addr=0x20; the following cycle instr_pc=0x20.
- redirect_pc=0x0000_0016 -> imem_addr=0x14, misalign_err=1 and still 1 after 10 cycles; rst clears it.
- With FETCH_BOUND_CHECK_EN, MEM_LAST_ADDR=100, sequential fetch -> last capture at pc 96, fetch_halted=1 at pc 100; redirect to 0 -> fetch_halted=0 and fetch resumes.
